// File: rtl/hash_stream_bridge_pkg.sv
// Shared types and sizing helpers for the hash stream bridge.
// Imported by the bridge top and its word packer.
package hash_stream_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FILL,
      ST_PUSH,
      ST_DRAIN
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int beats_per_word(input int io_w);
      return 32 / io_w;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hash_word_packer.sv
// Shifts host beats into a 32-bit word, first beat ending up on top.
// Also owns the shared beat counter used by FILL and DRAIN.
module hash_word_packer
   import hash_stream_bridge_pkg::*;
#(
   parameter int IO_W = 8,
   parameter int CW   = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            step,
   input  logic            shift,
   input  logic [IO_W-1:0] din,
   output logic [31:0]     word_nxt,
   output logic [CW-1:0]   cnt
);

   logic [31:0]   word_q, word_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      word_nxt = (word_q << IO_W) | 32'(din);
      word_d   = shift ? word_nxt : word_q;
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (step) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hash_stream_bridge.sv
// Bridges a narrow host beat stream to a 32-bit hash core and
// streams the resulting digest back to the host.
module hash_stream_bridge
   import hash_stream_bridge_pkg::*;
#(
   parameter int IO_W      = 8,
   parameter int HASH_W    = 256,
   parameter int MAX_WORDS = 20
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               rev,
   input  logic                               abort,
   input  logic [IO_W-1:0]                    din,
   input  logic                               rdy,
   output logic                               rq,
   output logic [IO_W-1:0]                    dout,
   output logic                               done,
   output logic                               err,
   output logic [clog2(MAX_WORDS+1)-1:0]      words,
   output logic                               core_start,
   output logic [31:0]                        core_data,
   output logic                               core_rdy,
   input  logic                               core_rq,
   input  logic                               core_done,
   input  logic [HASH_W-1:0]                  core_hash
);

   localparam int BEATS = beats_per_word(IO_W);
   localparam int NOUT  = HASH_W / IO_W;
   localparam int CW    = clog2(max2(BEATS, NOUT) + 1);
   localparam int WW    = clog2(MAX_WORDS + 1);

   state_e            state_q, state_d;
   logic              rq_q, rq_d;
   logic              err_q, err_d;
   logic [WW-1:0]     words_q, words_d;
   logic              core_start_q, core_start_d;
   logic [31:0]       core_data_q, core_data_d;
   logic [HASH_W-1:0] hash_q, hash_d;
   logic              rev_q, rev_d;
   logic              skip_q, skip_d;

   logic              xfer;
   logic              clr;
   logic [CW-1:0]     cnt;
   logic [31:0]       word_nxt;

   assign xfer = rq_q & rdy & ~abort;
   assign clr  = (state_d != state_q);

   hash_word_packer #(
      .IO_W (IO_W),
      .CW   (CW)
   ) u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .step     (xfer),
      .shift    (xfer && (state_q == ST_FILL)),
      .din      (din),
      .word_nxt (word_nxt),
      .cnt      (cnt)
   );

   always_comb begin
      state_d      = state_q;
      rq_d         = 1'b0;
      err_d        = err_q;
      words_d      = words_q;
      core_start_d = 1'b0;
      core_data_d  = core_data_q;
      hash_d       = hash_q;
      rev_d        = rev_q;
      skip_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               rev_d        = rev;
               err_d        = 1'b0;
               words_d      = '0;
               core_start_d = 1'b1;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (core_done) begin
               hash_d  = core_hash;
               rq_d    = 1'b1;
               state_d = ST_DRAIN;
            end else if (core_rq && !skip_q) begin
               if (words_q < WW'(MAX_WORDS)) begin
                  rq_d    = 1'b1;
                  state_d = ST_FILL;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FILL: begin
            if (xfer) begin
               if (cnt == CW'(BEATS - 1)) begin
                  core_data_d = word_nxt;
                  state_d     = ST_PUSH;
               end
            end else begin
               rq_d = 1'b1;
            end
         end
         ST_PUSH: begin
            // core needs a cycle to drop core_rq after taking a word
            words_d = words_q + WW'(1);
            skip_d  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_DRAIN: begin
            if (xfer) begin
               if (cnt == CW'(NOUT - 1)) begin
                  state_d = ST_IDLE;
               end
            end else begin
               rq_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         rq_d         = 1'b0;
         err_d        = err_q;
         words_d      = words_q;
         core_start_d = 1'b0;
         core_data_d  = core_data_q;
         hash_d       = hash_q;
         skip_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rq_q         <= 1'b0;
         err_q        <= 1'b0;
         words_q      <= '0;
         core_start_q <= 1'b0;
         core_data_q  <= '0;
         hash_q       <= '0;
         rev_q        <= 1'b0;
         skip_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rq_q         <= rq_d;
         err_q        <= err_d;
         words_q      <= words_d;
         core_start_q <= core_start_d;
         core_data_q  <= core_data_d;
         hash_q       <= hash_d;
         rev_q        <= rev_d;
         skip_q       <= skip_d;
      end
   end

   always_comb begin
      dout = '0;
      if ((state_q == ST_DRAIN) && rq_q) begin
         for (int k = 0; k < NOUT; k++) begin
            if (CW'(k) == cnt) begin
               dout = rev_q ? hash_q[k*IO_W +: IO_W]
                            : hash_q[HASH_W-1-k*IO_W -: IO_W];
            end
         end
      end
   end

   assign rq         = rq_q;
   assign done       = (state_q == ST_DRAIN);
   assign err        = err_q;
   assign words      = words_q;
   assign core_start = core_start_q;
   assign core_data  = core_data_q;
   assign core_rdy   = (state_q == ST_PUSH);

endmodule

// File: tb/tb_hash_stream_bridge.sv
// Directed self-checking bench for hash_stream_bridge (IO_W=8).
// Covers packing, word limit, drain order, abort and async reset.
module tb_hash_stream_bridge;
   import hash_stream_bridge_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         rev = 1'b0;
   logic         abort = 1'b0;
   logic [7:0]   din = '0;
   logic         rdy = 1'b0;
   logic         core_rq = 1'b0;
   logic         core_done = 1'b0;
   logic [255:0] core_hash = '0;
   logic         rq, done, err, core_start, core_rdy;
   logic [7:0]   dout;
   logic [4:0]   words;
   logic [31:0]  core_data;

   int n_run = 0;
   int n_fail = 0;
   int rdy_cnt = 0;
   int c0;
   logic [7:0]   last;
   logic [255:0] hseq;

   hash_stream_bridge #(
      .IO_W      (8),
      .HASH_W    (256),
      .MAX_WORDS (20)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rev        (rev),
      .abort      (abort),
      .din        (din),
      .rdy        (rdy),
      .rq         (rq),
      .dout       (dout),
      .done       (done),
      .err        (err),
      .words      (words),
      .core_start (core_start),
      .core_data  (core_data),
      .core_rdy   (core_rdy),
      .core_rq    (core_rq),
      .core_done  (core_done),
      .core_hash  (core_hash)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (core_rdy) rdy_cnt <= rdy_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rq;
      int t;
      t = 0;
      while (!rq && t < 10) begin
         tick;
         t++;
      end
      chk("rq_up", 64'(rq), 64'd1);
   endtask

   task automatic host_beat(input logic [7:0] b);
      wait_rq;
      din = b;
      rdy = 1'b1;
      tick;
      rdy = 1'b0;
      chk("rq_drop", 64'(rq), 64'd0);
   endtask

   task automatic do_start(input logic r);
      start = 1'b1;
      rev   = r;
      tick;
      start = 1'b0;
      chk("core_start", 64'(core_start), 64'd1);
      chk("st_wait", 64'(u_dut.state_q), 64'(ST_WAIT));
      chk("err_clr", 64'(err), 64'd0);
      chk("words_clr", 64'(words), 64'd0);
      tick;
      chk("core_start_1", 64'(core_start), 64'd0);
   endtask

   task automatic core_word(input logic [31:0] w);
      int t;
      int c;
      t = 0;
      c = rdy_cnt;
      core_rq = 1'b1;
      do begin
         tick;
         t++;
      end while (u_dut.state_q != ST_FILL && t < 4);
      core_rq = 1'b0;
      chk("enter_fill", 64'(u_dut.state_q), 64'(ST_FILL));
      for (int j = 0; j < 4; j++) host_beat(w[31-8*j -: 8]);
      chk("push_rdy", 64'(core_rdy), 64'd1);
      chk("push_data", 64'(core_data), 64'(w));
      tick;
      chk("rdy_once", 64'(rdy_cnt - c), 64'd1);
      chk("rdy_low", 64'(core_rdy), 64'd0);
   endtask

   task automatic drain(input logic r, input logic [255:0] h,
                        output logic [7:0] lst);
      logic [255:0] s;
      lst = '0;
      for (int k = 0; k < 32; k++) begin
         wait_rq;
         chk("done_hi", 64'(done), 64'd1);
         s = h >> (r ? 8 * k : 248 - 8 * k);
         chk($sformatf("beat%0d", k), 64'(dout), 64'(s[7:0]));
         lst = dout;
         rdy = 1'b1;
         tick;
         rdy = 1'b0;
         chk("drain_rq_drop", 64'(rq), 64'd0);
      end
      chk("done_fall", 64'(done), 64'd0);
      chk("drain_idle", 64'(u_dut.state_q), 64'(ST_IDLE));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) hseq[255-8*i -: 8] = 8'(i + 1);

      tick;
      chk("rst_state", 64'(u_dut.state_q), 64'(ST_IDLE));
      chk("rst_rq", 64'(rq), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_cstart", 64'(core_start), 64'd0);
      chk("rst_crdy", 64'(core_rdy), 64'd0);
      chk("rst_words", 64'(words), 64'd0);
      chk("rst_cdata", 64'(core_data), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      #2 rst = 1'b0;
      tick;

      // single word packing and core_rq skip after PUSH
      do_start(1'b0);
      core_word(32'h12345678);
      chk("words_1", 64'(words), 64'd1);
      core_rq = 1'b1;
      tick;
      core_rq = 1'b0;
      chk("skip_wait", 64'(u_dut.state_q), 64'(ST_WAIT));
      chk("cdata_hold", 64'(core_data), 64'h12345678);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_wait", 64'(u_dut.state_q), 64'(ST_IDLE));
      chk("abort_words", 64'(words), 64'd1);

      // twenty words, then an over-limit request
      do_start(1'b0);
      for (int i = 0; i < 20; i++)
         core_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
      chk("words_20", 64'(words), 64'd20);
      c0 = rdy_cnt;
      core_rq = 1'b1;
      tick;
      tick;
      core_rq = 1'b0;
      chk("ovr_err", 64'(err), 64'd1);
      chk("ovr_idle", 64'(u_dut.state_q), 64'(ST_IDLE));
      tick;
      chk("ovr_no_rdy", 64'(rdy_cnt - c0), 64'd0);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("idle_abort_err", 64'(err), 64'd1);

      // core_done beats simultaneous core_rq; start ignored in DRAIN
      do_start(1'b0);
      c0 = rdy_cnt;
      core_hash = 256'd1;
      core_done = 1'b1;
      core_rq = 1'b1;
      tick;
      core_done = 1'b0;
      core_rq = 1'b0;
      chk("prio_drain", 64'(u_dut.state_q), 64'(ST_DRAIN));
      chk("prio_done", 64'(done), 64'd1);
      start = 1'b1;
      rev = 1'b1;
      tick;
      start = 1'b0;
      chk("start_ign", 64'(u_dut.state_q), 64'(ST_DRAIN));
      drain(1'b0, 256'd1, last);
      chk("last_fwd", 64'(last), 64'h01);
      chk("prio_no_fill", 64'(rdy_cnt - c0), 64'd0);

      // reversed digest order
      do_start(1'b1);
      core_hash = hseq;
      core_done = 1'b1;
      tick;
      core_done = 1'b0;
      chk("rev_first", 64'(dout), 64'h20);
      drain(1'b1, hseq, last);
      chk("rev_last", 64'(last), 64'h01);

      // abort mid-FILL with a beat offered the same cycle
      do_start(1'b0);
      c0 = rdy_cnt;
      core_rq = 1'b1;
      tick;
      core_rq = 1'b0;
      host_beat(8'hAA);
      host_beat(8'hBB);
      tick;
      abort = 1'b1;
      rdy = 1'b1;
      din = 8'hCC;
      tick;
      abort = 1'b0;
      rdy = 1'b0;
      chk("abf_idle", 64'(u_dut.state_q), 64'(ST_IDLE));
      chk("abf_rq", 64'(rq), 64'd0);
      tick;
      chk("abf_no_rdy", 64'(rdy_cnt - c0), 64'd0);
      do_start(1'b0);
      core_word(32'hCAFEF00D);
      chk("fresh_words", 64'(words), 64'd1);

      // async reset during DRAIN
      core_hash = hseq;
      core_done = 1'b1;
      tick;
      core_done = 1'b0;
      host_beat(8'h00);
      wait_rq;
      chk("pre_rst_dout", 64'(dout), 64'h02);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 64'(u_dut.state_q), 64'(ST_IDLE));
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_rq", 64'(rq), 64'd0);
      chk("arst_dout", 64'(dout), 64'd0);
      chk("arst_words", 64'(words), 64'd0);
      chk("arst_cdata", 64'(core_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      chk("post_rq", 64'(rq), 64'd0);
      chk("post_crdy", 64'(core_rdy), 64'd0);
      chk("post_idle", 64'(u_dut.state_q), 64'(ST_IDLE));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
